// File: rtl/cic_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cic_pkg : shared state type, counter widths and scale/saturate helper     |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
package cic_pkg;

    localparam int CIC_LEN       = 3;
    localparam int CIC_FLUSH_CYC = 4;
    localparam int FLUSH_CNT_W   = $clog2(CIC_FLUSH_CYC + 1);
    localparam int PRIME_CNT_W   = $clog2(CIC_LEN + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        PRIME = 2'd2,
        RUN   = 2'd3
    } ctrl_state_t;

    typedef struct packed {
        logic        ovf;
        logic [63:0] val;
    } sat_res_t;

    // Arithmetic right shift, then clamp to a signed field of 'width' bits.
    function automatic sat_res_t sat_shift(input logic signed [63:0] value,
                                           input logic [7:0]         shift,
                                           input int                 width);
        logic signed [63:0] t;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sat_res_t           r;
        t     = value >>> shift;
        hi    = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo    = -(64'sd1 <<< (width - 1));
        r.ovf = 1'b0;
        r.val = t;
        if (t > hi) begin
            r.ovf = 1'b1;
            r.val = hi;
        end else if (t < lo) begin
            r.ovf = 1'b1;
            r.val = lo;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cic_deci_ctrl_out_scale.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cic_out_scale : strobe delay, capture, shift/saturate and output regs     |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module cic_out_scale
    import cic_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int WIDTH_EX = 18,
    parameter int SHIFT_W  = 6
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              strobe,
    input  logic                              flush,
    input  logic                              clr_sat,
    input  logic [SHIFT_W-1:0]                shift,
    input  logic signed [WIDTH+WIDTH_EX-1:0]  cic_dout,
    output logic signed [WIDTH-1:0]           dout,
    output logic                              dout_valid,
    output logic                              sat
);

    logic               s1;
    logic               fire;
    logic signed [63:0] dout_ext;
    sat_res_t           res;
    logic               unused_hi;

    // The datapath output settles one cycle after its strobe, so capture on s1.
    always_comb begin
        dout_ext  = 64'(cic_dout);
        res       = sat_shift(dout_ext, 8'(shift), WIDTH);
        fire      = s1 & ~flush;
        unused_hi = ^res.val[63:WIDTH];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1         <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            sat        <= 1'b0;
        end else begin
            s1         <= strobe & ~flush;
            dout_valid <= fire;
            if (fire) begin
                dout <= res.val[WIDTH-1:0];
            end
            if (clr_sat) begin
                sat <= 1'b0;
            end else if (fire && res.ovf) begin
                sat <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cic_deci_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cic_deci_ctrl : config handshake, flush/prime sequencing and output scale |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module cic_deci_ctrl
    import cic_pkg::*;
#(
    parameter int MAX_RATE  = 64,
    parameter int LEN       = CIC_LEN,
    parameter int WIDTH     = 16,
    parameter int WIDTH_EX  = 18,
    parameter int FLUSH_CYC = CIC_FLUSH_CYC,
    parameter int DEF_RATE  = 8,
    parameter int DEF_SHIFT = 9
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 en,
    input  logic                                 in_cke,
    input  logic                                 cfg_valid,
    output logic                                 cfg_ready,
    input  logic [$clog2(MAX_RATE):0]            cfg_rate,
    input  logic [$clog2(WIDTH+WIDTH_EX)-1:0]    cfg_shift,
    output logic                                 cfg_err,
    output logic                                 cic_rst,
    output logic                                 cic_cke,
    output logic [$clog2(MAX_RATE):0]            cic_rate,
    input  logic                                 cic_cke_out,
    input  logic signed [WIDTH+WIDTH_EX-1:0]     cic_dout,
    output logic signed [WIDTH-1:0]              dout,
    output logic                                 dout_valid,
    output logic                                 sat,
    output logic                                 busy
);

    localparam int RATE_W  = $clog2(MAX_RATE) + 1;
    localparam int SHIFT_W = $clog2(WIDTH + WIDTH_EX);

    ctrl_state_t            state;
    ctrl_state_t            state_nxt;
    logic [FLUSH_CNT_W-1:0] flush_cnt;
    logic [FLUSH_CNT_W-1:0] flush_cnt_nxt;
    logic [PRIME_CNT_W-1:0] prime_cnt;
    logic [PRIME_CNT_W-1:0] prime_cnt_nxt;
    logic [SHIFT_W-1:0]     shift;
    logic                   xfer;
    logic                   cfg_bad;
    logic                   cfg_load;
    logic                   take;
    logic                   flush;

    always_comb begin
        xfer     = cfg_valid & cfg_ready;
        cfg_bad  = (cfg_rate == '0) || (cfg_rate > RATE_W'(MAX_RATE));
        cfg_load = xfer & ~cfg_bad;
        take     = cic_cke_out & en & (state == RUN) & ~cfg_load;
        flush    = ~en | cfg_load | (state != RUN);
    end

    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = '0;
        prime_cnt_nxt = prime_cnt;
        cic_rst       = 1'b1;
        cic_cke       = 1'b0;
        busy          = 1'b0;
        cfg_ready     = 1'b1;
        case (state)
            IDLE: begin
                state_nxt = FLUSH;
            end
            FLUSH: begin
                busy      = 1'b1;
                cfg_ready = 1'b0;
                if (flush_cnt == FLUSH_CNT_W'(FLUSH_CYC - 1)) begin
                    state_nxt = PRIME;
                end else begin
                    flush_cnt_nxt = flush_cnt + 1'b1;
                end
            end
            PRIME: begin
                cic_rst = 1'b0;
                cic_cke = in_cke;
                busy    = 1'b1;
                if (cic_cke_out) begin
                    if (prime_cnt == PRIME_CNT_W'(LEN - 1)) begin
                        state_nxt = RUN;
                    end else begin
                        prime_cnt_nxt = prime_cnt + 1'b1;
                    end
                end
            end
            RUN: begin
                cic_rst = 1'b0;
                cic_cke = in_cke;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // Disable beats a restart; a legal config always re-flushes the datapath.
        if (!en) begin
            state_nxt = IDLE;
        end else if (cfg_load) begin
            state_nxt = FLUSH;
        end
        if (state_nxt != state) begin
            flush_cnt_nxt = '0;
            prime_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            flush_cnt <= '0;
            prime_cnt <= '0;
            cic_rate  <= RATE_W'(DEF_RATE);
            shift     <= SHIFT_W'(DEF_SHIFT);
            cfg_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
            prime_cnt <= prime_cnt_nxt;
            cfg_err   <= xfer & cfg_bad;
            if (cfg_load) begin
                cic_rate <= cfg_rate;
                shift    <= cfg_shift;
            end
        end
    end

    cic_out_scale #(
        .WIDTH    (WIDTH),
        .WIDTH_EX (WIDTH_EX),
        .SHIFT_W  (SHIFT_W)
    ) u_scale (
        .clk        (clk),
        .rst        (rst),
        .strobe     (take),
        .flush      (flush),
        .clr_sat    (cfg_load),
        .shift      (shift),
        .cic_dout   (cic_dout),
        .dout       (dout),
        .dout_valid (dout_valid),
        .sat        (sat)
    );

endmodule
`default_nettype wire

// File: tb/tb_cic_deci_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cic_deci_ctrl : scenario tasks plus randomized run vs a phase model    |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_cic_deci_ctrl;

    localparam int MAX_RATE  = 64;
    localparam int LEN       = 3;
    localparam int WIDTH     = 16;
    localparam int WIDTH_EX  = 18;
    localparam int FLUSH_CYC = 4;
    localparam int DEF_RATE  = 8;
    localparam int DEF_SHIFT = 9;
    localparam int DW        = WIDTH + WIDTH_EX;
    localparam int RW        = $clog2(MAX_RATE) + 1;
    localparam int SW        = $clog2(DW);
    localparam int BW        = 1 + WIDTH + 6 + RW;
    localparam int P_IDLE = 0, P_FLUSH = 1, P_PRIME = 2, P_RUN = 3;

    logic                 clk = 1'b0;
    logic                 rst, en, in_cke, cfg_valid, cic_cke_out;
    logic [RW-1:0]        cfg_rate;
    logic [SW-1:0]        cfg_shift;
    logic signed [DW-1:0] cic_dout;
    logic                 cfg_ready, cfg_err, cic_rst, cic_cke, dout_valid, sat, busy;
    logic [RW-1:0]        cic_rate;
    logic signed [WIDTH-1:0] dout;

    int n_vec = 0, n_err = 0, cyc = 0, ph = 0;

    int                   m_phase, m_cnt;
    logic [RW-1:0]        m_rate;
    logic [SW-1:0]        m_shift;
    logic                 m_sat, m_valid, m_err, m_pend;
    logic [WIDTH-1:0]     m_dout;

    wire [BW-1:0] act_bus = {dout_valid, dout, sat, cfg_err, cic_rst, busy, cfg_ready, cic_cke, cic_rate};

    cic_deci_ctrl #(
        .MAX_RATE(MAX_RATE), .LEN(LEN), .WIDTH(WIDTH), .WIDTH_EX(WIDTH_EX),
        .FLUSH_CYC(FLUSH_CYC), .DEF_RATE(DEF_RATE), .DEF_SHIFT(DEF_SHIFT)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .in_cke(in_cke),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_rate(cfg_rate),
        .cfg_shift(cfg_shift), .cfg_err(cfg_err), .cic_rst(cic_rst),
        .cic_cke(cic_cke), .cic_rate(cic_rate), .cic_cke_out(cic_cke_out),
        .cic_dout(cic_dout), .dout(dout), .dout_valid(dout_valid),
        .sat(sat), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [WIDTH:0] ref_scale(input logic signed [DW-1:0] v, input int sh);
        longint t, hi, lo;
        t  = longint'(v) >>> sh;
        hi = (longint'(1) <<< (WIDTH - 1)) - 1;
        lo = -hi - 1;
        if (t > hi) return {1'b1, hi[WIDTH-1:0]};
        if (t < lo) return {1'b1, lo[WIDTH-1:0]};
        return {1'b0, t[WIDTH-1:0]};
    endfunction

    function automatic logic [BW-1:0] exp_bus();
        logic r, b, rdy, ck;
        r   = (m_phase == P_IDLE) || (m_phase == P_FLUSH);
        b   = (m_phase == P_FLUSH) || (m_phase == P_PRIME);
        rdy = (m_phase != P_FLUSH);
        ck  = in_cke && !r;
        return {m_valid, m_dout, m_sat, m_err, r, b, rdy, ck, m_rate};
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE; m_cnt = 0;
        m_rate  = RW'(DEF_RATE); m_shift = SW'(DEF_SHIFT);
        m_sat = 1'b0; m_valid = 1'b0; m_err = 1'b0; m_pend = 1'b0; m_dout = '0;
    endtask

    // Advance the reference model by one clock using the inputs currently applied.
    task automatic tick();
        logic xfer, legal, drop, ovf;
        logic [WIDTH-1:0] val;
        xfer    = cfg_valid && (m_phase != P_FLUSH);
        legal   = xfer && (cfg_rate != 0) && (int'(cfg_rate) <= MAX_RATE);
        drop    = !en || legal || (m_phase != P_RUN);
        m_err   = xfer && !legal;
        m_valid = m_pend && !drop;
        if (m_valid) begin
            {ovf, val} = ref_scale(cic_dout, int'(m_shift));
            m_dout = val;
            m_sat  = m_sat | ovf;
        end
        m_pend = cic_cke_out && en && !legal && (m_phase == P_RUN);
        if (legal) begin
            m_rate = cfg_rate; m_shift = cfg_shift; m_sat = 1'b0;
        end
        if (!en) begin
            m_phase = P_IDLE; m_cnt = 0;
        end else if (legal || m_phase == P_IDLE) begin
            m_phase = P_FLUSH; m_cnt = 0;
        end else if (m_phase == P_FLUSH) begin
            if (m_cnt == FLUSH_CYC - 1) begin m_phase = P_PRIME; m_cnt = 0; end
            else m_cnt++;
        end else if (m_phase == P_PRIME && cic_cke_out) begin
            if (m_cnt == LEN - 1) begin m_phase = P_RUN; m_cnt = 0; end
            else m_cnt++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; in_cke = 1'b0; cfg_valid = 1'b0; cfg_rate = '0;
        cfg_shift = '0; cic_cke_out = 1'b0; cic_dout = '0;
        #1 rst = 1'b0;
        model_reset();
        #2;
        n_vec++;
        if (act_bus !== exp_bus()) begin
            n_err++; $display("FAIL reset_values: got %h want %h", act_bus, exp_bus());
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        tick();
        n_vec++;
        if (act_bus !== exp_bus()) begin
            n_err++; $display("FAIL idle_after_reset: got %h want %h", act_bus, exp_bus());
        end
    endtask

    task automatic test_flush_prime();
        int rst_hi = 0, npulse = 0, first = -1;
        en = 1'b1; in_cke = 1'b1; cic_dout = DW'(100 * 512); ph = 0;
        for (int k = 0; k < 60; k++) begin
            cic_cke_out = !cic_rst && (ph % 8 == 7);
            if (cic_cke_out) npulse++;
            tick();
            ph = cic_rst ? 0 : ph + 1;
            if (cic_rst) rst_hi++;
            if (dout_valid && first < 0) first = npulse;
            n_vec++;
            if (act_bus !== exp_bus()) begin
                n_err++; $display("FAIL flush_prime cyc %0d: got %h want %h", cyc, act_bus, exp_bus());
            end
        end
        n_vec++;
        if (rst_hi != FLUSH_CYC) begin
            n_err++; $display("FAIL flush_len: got %0d want %0d", rst_hi, FLUSH_CYC);
        end
        n_vec++;
        if (first != LEN + 1) begin
            n_err++; $display("FAIL first_output_pulse: got %0d want %0d", first, LEN + 1);
        end
    endtask

    task automatic test_dc_rate8();
        int nv = 0, last = -1;
        for (int k = 0; k < 80; k++) begin
            cic_cke_out = !cic_rst && (ph % 8 == 7);
            tick();
            ph = cic_rst ? 0 : ph + 1;
            n_vec++;
            if (act_bus !== exp_bus()) begin
                n_err++; $display("FAIL dc_rate8 cyc %0d: got %h want %h", cyc, act_bus, exp_bus());
            end
            if (dout_valid) begin
                nv++;
                n_vec++;
                if (dout !== 16'sd100) begin
                    n_err++; $display("FAIL dc_value: got %0d want 100", dout);
                end
                if (last >= 0) begin
                    n_vec++;
                    if (cyc - last != 8) begin
                        n_err++; $display("FAIL dc_spacing: got %0d want 8", cyc - last);
                    end
                end
                last = cyc;
            end
        end
        n_vec++;
        if (nv != 10) begin
            n_err++; $display("FAIL dc_count: got %0d want 10", nv);
        end
    endtask

    task automatic test_bad_cfg();
        int nerr_p = 0, nv = 0;
        for (int k = 0; k < 48; k++) begin
            cfg_valid = (k == 5) || (k == 20);
            cfg_rate  = (k == 5) ? RW'(0) : RW'(MAX_RATE + 1);
            cfg_shift = SW'(3);
            cic_cke_out = !cic_rst && (ph % 8 == 7);
            tick();
            ph = cic_rst ? 0 : ph + 1;
            if (cfg_err) nerr_p++;
            if (dout_valid) nv++;
            n_vec++;
            if (act_bus !== exp_bus()) begin
                n_err++; $display("FAIL bad_cfg cyc %0d: got %h want %h", cyc, act_bus, exp_bus());
            end
        end
        cfg_valid = 1'b0;
        n_vec++;
        if (nerr_p != 2) begin
            n_err++; $display("FAIL cfg_err_count: got %0d want 2", nerr_p);
        end
        n_vec++;
        if (cic_rate !== RW'(8) || busy !== 1'b0 || cic_rst !== 1'b0 || nv != 6) begin
            n_err++; $display("FAIL bad_cfg_state: rate %0d busy %b cic_rst %b outs %0d want 8 0 0 6",
                              cic_rate, busy, cic_rst, nv);
        end
    endtask

    task automatic test_sat();
        for (int k = 0; k < 76; k++) begin
            cfg_valid = (k == 0);
            cfg_rate  = RW'(8);
            cfg_shift = SW'(0);
            cic_dout  = (k < 60) ? DW'(longint'(1) <<< 32) : DW'(-(longint'(1) <<< 33));
            cic_cke_out = !cic_rst && (ph % 8 == 7);
            tick();
            ph = cic_rst ? 0 : ph + 1;
            n_vec++;
            if (act_bus !== exp_bus()) begin
                n_err++; $display("FAIL sat cyc %0d: got %h want %h", cyc, act_bus, exp_bus());
            end
            if (k == 59) begin
                n_vec++;
                if (dout !== 16'sh7fff || sat !== 1'b1) begin
                    n_err++; $display("FAIL sat_pos: dout %0d sat %b want 32767 1", dout, sat);
                end
            end
        end
        n_vec++;
        if (dout !== 16'sh8000 || sat !== 1'b1) begin
            n_err++; $display("FAIL sat_neg: dout %0d sat %b want -32768 1", dout, sat);
        end
        cic_cke_out = 1'b0;
        cfg_valid = 1'b1; cfg_rate = RW'(8); cfg_shift = SW'(9); cic_dout = DW'(100 * 512);
        tick();
        cfg_valid = 1'b0;
        n_vec++;
        if (sat !== 1'b0 || act_bus !== exp_bus()) begin
            n_err++; $display("FAIL sat_clear: sat %b bus %h want 0 bus %h", sat, act_bus, exp_bus());
        end
    endtask

    task automatic test_restart16();
        int npulse = 0, first = -1;
        for (int k = 0; k < 60; k++) begin
            cic_cke_out = !cic_rst && (ph % 8 == 7);
            tick();
            ph = cic_rst ? 0 : ph + 1;
        end
        cic_cke_out = 1'b0;
        cfg_valid = 1'b1; cfg_rate = RW'(16); cfg_shift = SW'(12); cic_dout = DW'(100 * 4096);
        tick();
        cfg_valid = 1'b0;
        ph = 0;
        n_vec++;
        if (cic_rst !== 1'b1 || busy !== 1'b1 || cic_rate !== RW'(16)) begin
            n_err++; $display("FAIL restart_flush: cic_rst %b busy %b rate %0d want 1 1 16",
                              cic_rst, busy, cic_rate);
        end
        for (int k = 0; k < 120; k++) begin
            cic_cke_out = !cic_rst && (ph % 16 == 15);
            if (cic_cke_out) npulse++;
            tick();
            ph = cic_rst ? 0 : ph + 1;
            if (dout_valid && first < 0) first = npulse;
            n_vec++;
            if (act_bus !== exp_bus() || (dout_valid && dout !== 16'sd100)) begin
                n_err++; $display("FAIL restart16 cyc %0d: got %h want %h", cyc, act_bus, exp_bus());
            end
        end
        n_vec++;
        if (first != LEN + 1) begin
            n_err++; $display("FAIL restart_first_pulse: got %0d want %0d", first, LEN + 1);
        end
    endtask

    task automatic test_en_drop();
        bit hit = 0;
        int nv = 0;
        for (int k = 0; k < 40 && !hit; k++) begin
            cic_cke_out = !cic_rst && (ph % 16 == 15);
            if (cic_cke_out) begin
                en = 1'b0; hit = 1;
            end
            tick();
            ph = cic_rst ? 0 : ph + 1;
        end
        n_vec++;
        if (!hit || cic_rst !== 1'b1 || busy !== 1'b0) begin
            n_err++; $display("FAIL en_drop_idle: hit %0d cic_rst %b busy %b want 1 1 0", hit, cic_rst, busy);
        end
        cic_cke_out = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (dout_valid) nv++;
            n_vec++;
            if (act_bus !== exp_bus()) begin
                n_err++; $display("FAIL en_drop cyc %0d: got %h want %h", cyc, act_bus, exp_bus());
            end
        end
        n_vec++;
        if (nv != 0) begin
            n_err++; $display("FAIL en_drop_output: got %0d outputs want 0", nv);
        end
    endtask

    task automatic test_async_reset();
        bit hit = 0;
        en = 1'b1; cfg_valid = 1'b0; ph = 0;
        for (int k = 0; k < 80 && !hit; k++) begin
            cic_cke_out = !cic_rst && (ph % 16 == 15);
            tick();
            ph = cic_rst ? 0 : ph + 1;
            n_vec++;
            if (act_bus !== exp_bus()) begin
                n_err++; $display("FAIL pre_reset cyc %0d: got %h want %h", cyc, act_bus, exp_bus());
            end
            hit = (m_phase == P_PRIME) && (m_cnt == 1);
        end
        n_vec++;
        if (!hit) begin
            n_err++; $display("FAIL reach_prime: got 0 want 1");
        end
        #1 rst = 1'b0;
        model_reset();
        #1;
        n_vec++;
        if (act_bus !== exp_bus()) begin
            n_err++; $display("FAIL async_reset: got %h want %h", act_bus, exp_bus());
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (act_bus !== exp_bus()) begin
            n_err++; $display("FAIL reset_hold: got %h want %h", act_bus, exp_bus());
        end
        en = 1'b0; cic_cke_out = 1'b0; rst = 1'b1;
        tick();
    endtask

    task automatic test_random();
        for (int k = 0; k < 1200; k++) begin
            en          = ($urandom_range(0, 99) != 0);
            in_cke      = 1'($urandom_range(0, 1));
            cic_cke_out = ($urandom_range(0, 3) == 0);
            cic_dout    = DW'({$urandom, $urandom});
            cfg_valid   = ($urandom_range(0, 39) == 0);
            cfg_rate    = RW'($urandom_range(0, 70));
            cfg_shift   = SW'($urandom_range(0, 63));
            tick();
            n_vec++;
            if (act_bus !== exp_bus()) begin
                n_err++; $display("FAIL random cyc %0d: got %h want %h", cyc, act_bus, exp_bus());
            end
        end
    endtask

    initial begin
        test_reset();
        test_flush_prime();
        test_dc_rate8();
        test_bad_cfg();
        test_sat();
        test_restart16();
        test_en_drop();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
